cmd_dispatcher: RTL and testbench

- Consumer stage for the 64-bit command FIFO that the host EBI interface fills.
- Pops one command at a time and holds it until the internal sample-time counter reaches the command's start time.
- Then issues the command as a register write on the internal unit bus (pin controllers, DAC/ADC units) using a valid/ack handshake with timeout.
- Handles time-control pseudo-commands addressed to unit 0xFF internally.

---
 rtl/cmd_dispatcher.sv | 168 ++++++++++++++++
 tb/tb_cmd_dispatcher.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher
// Consumer stage of the 64-bit host command FIFO. Pops one command at a
// time, holds it until the sample-time counter reaches the command's start
// time, then issues it as a register write on the internal unit bus with a
// valid/ack handshake and an ack timeout. Commands addressed to CTRL_UNIT
// are time-control pseudo-commands handled here and never reach the bus.
//
// Command word: [63:32] start_time, [31:24] unit, [23:16] reg, [15:0] data
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_fifo_data_out   FIFO read data, valid the cycle after cmd_fifo_rd_en
//   cmd_fifo_empty      FIFO empty flag
//   cmd_fifo_rd_en      one-cycle pop strobe (high only in POP)
//   bus_unit/reg/data   write target and payload, stable while bus_valid
//   bus_valid, bus_ack  write handshake
//   cur_time            free-running sample-time counter
//   busy                high whenever the FSM is not idle
//   timeout_err         sticky ack-timeout flag, cleared by err_clear
//   cmd_count           completed commands (issued or handled), wraps
module cmd_dispatcher #(
  parameter int         ACK_TIMEOUT = 255,
  parameter logic [7:0] CTRL_UNIT   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cmd_fifo_data_out,
  input  logic        cmd_fifo_empty,
  output logic        cmd_fifo_rd_en,
  output logic [7:0]  bus_unit,
  output logic [7:0]  bus_reg,
  output logic [15:0] bus_data,
  output logic        bus_valid,
  input  logic        bus_ack,
  output logic [31:0] cur_time,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clear,
  output logic [15:0] cmd_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_ISSUE = 3'd5;

  localparam logic [15:0] TO_LIMIT = 16'(ACK_TIMEOUT);

  localparam logic [7:0] CTRL_NOP   = 8'h00;
  localparam logic [7:0] CTRL_CLEAR = 8'h01;

  logic [2:0]  state;
  logic [63:0] cmd;
  logic [15:0] to_cnt;
  logic [15:0] to_nxt;

  logic [31:0] cmd_start;
  logic [7:0]  cmd_unit;
  logic [7:0]  cmd_reg;
  logic [15:0] cmd_data;

  assign cmd_start = cmd[63:32];
  assign cmd_unit  = cmd[31:24];
  assign cmd_reg   = cmd[23:16];
  assign cmd_data  = cmd[15:0];

  assign to_nxt = to_cnt + 16'd1;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cmd            <= '0;
      to_cnt         <= '0;
      cmd_fifo_rd_en <= 1'b0;
      bus_unit       <= '0;
      bus_reg        <= '0;
      bus_data       <= '0;
      bus_valid      <= 1'b0;
      cur_time       <= '0;
      timeout_err    <= 1'b0;
      cmd_count      <= '0;
    end else begin
      // Defaults; later assignments in the case below take priority, so a
      // control clear overrides the increment and a timeout overrides
      // err_clear in the same cycle.
      cur_time <= cur_time + 32'd1;
      if (err_clear)
        timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!cmd_fifo_empty) begin
            cmd_fifo_rd_en <= 1'b1;
            state          <= S_POP;
          end
        end

        S_POP: begin
          cmd_fifo_rd_en <= 1'b0;
          state          <= S_LATCH;
        end

        S_LATCH: begin
          cmd <= cmd_fifo_data_out;
          // Compare directly against the incoming word so a command whose
          // start time has already passed skips WAIT and reaches the bus
          // four cycles after the FIFO goes non-empty.
          if (cur_time >= cmd_fifo_data_out[63:32])
            state <= S_EXEC;
          else
            state <= S_WAIT;
        end

        S_WAIT: begin
          // Plain unsigned compare: after a wrap a large start time simply
          // waits for the counter to climb back up to it.
          if (cur_time >= cmd_start)
            state <= S_EXEC;
        end

        S_EXEC: begin
          if (cmd_unit == CTRL_UNIT) begin
            case (cmd_reg)
              CTRL_CLEAR: cur_time <= '0;
              CTRL_NOP:   ;
              default:    ;
            endcase
            cmd_count <= cmd_count + 16'd1;
            state     <= S_IDLE;
          end else begin
            bus_unit  <= cmd_unit;
            bus_reg   <= cmd_reg;
            bus_data  <= cmd_data;
            bus_valid <= 1'b1;
            to_cnt    <= '0;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Ack is checked first so an ack arriving on the timeout cycle
          // still completes the write without flagging an error.
          if (bus_ack) begin
            bus_valid <= 1'b0;
            cmd_count <= cmd_count + 16'd1;
            state     <= S_IDLE;
          end else if (to_nxt >= TO_LIMIT) begin
            bus_valid   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_nxt;
          end
        end

        default: begin
          cmd_fifo_rd_en <= 1'b0;
          bus_valid      <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed testbench for cmd_dispatcher: a small FIFO model feeds commands,
// an ack responder answers bus_valid after a programmable number of cycles,
// and each scenario task checks its own hand-computed expectations.
module tb_cmd_dispatcher;

  logic        clk;
  logic        rst;
  logic [63:0] fifo_dout;
  logic        fifo_empty;
  logic        rd_en;
  logic [7:0]  bus_unit;
  logic [7:0]  bus_reg;
  logic [15:0] bus_data;
  logic        bus_valid;
  logic        bus_ack;
  logic [31:0] cur_time;
  logic        busy;
  logic        timeout_err;
  logic        err_clear;
  logic [15:0] cmd_count;

  cmd_dispatcher #(.ACK_TIMEOUT(8), .CTRL_UNIT(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .cmd_fifo_data_out(fifo_dout), .cmd_fifo_empty(fifo_empty),
    .cmd_fifo_rd_en(rd_en),
    .bus_unit(bus_unit), .bus_reg(bus_reg), .bus_data(bus_data),
    .bus_valid(bus_valid), .bus_ack(bus_ack),
    .cur_time(cur_time), .busy(busy),
    .timeout_err(timeout_err), .err_clear(err_clear),
    .cmd_count(cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears one cycle after the pop strobe; unaffected by rst
  logic [63:0] mem [0:63];
  int push_cnt = 0;
  int pop_cnt = 0;
  assign fifo_empty = (push_cnt == pop_cnt);
  always @(posedge clk)
    if (rd_en && (push_cnt != pop_cnt)) begin
      fifo_dout <= mem[pop_cnt % 64];
      pop_cnt   <= pop_cnt + 1;
    end

  task automatic push(input logic [31:0] t, input logic [7:0] u,
                      input logic [7:0] r, input logic [15:0] d);
    mem[push_cnt % 64] = {t, u, r, d};
    push_cnt = push_cnt + 1;
  endtask

  // Ack responder: ack after ack_wait valid cycles, never if negative
  int ack_wait = 0;
  int vcnt = 0;
  initial bus_ack = 1'b0;
  always @(negedge clk) begin
    if (bus_valid) begin
      bus_ack = (ack_wait >= 0) && (vcnt == ack_wait);
      vcnt = vcnt + 1;
    end else begin
      bus_ack = 1'b0;
      vcnt = 0;
    end
  end

  // Monitor: rd_en pulses, bus_valid rising edges, any bus use of unit 0xFF
  int rd_pulses = 0;
  int nrise = 0;
  int ff_seen = 0;
  logic pv = 1'b0;
  int          rise_cyc [0:31];
  logic [7:0]  rise_u   [0:31];
  logic [31:0] rise_t   [0:31];
  always @(negedge clk) begin
    if (rd_en) rd_pulses = rd_pulses + 1;
    if (bus_valid && bus_unit == 8'hFF) ff_seen = ff_seen + 1;
    if (bus_valid && !pv && nrise < 32) begin
      rise_cyc[nrise] = cyc;
      rise_u[nrise]   = bus_unit;
      rise_t[nrise]   = cur_time;
      nrise = nrise + 1;
    end
    pv = bus_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_count(input logic [15:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cmd_count == target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    n_cmp++; if ({bus_valid, rd_en, busy, timeout_err} !== 4'b0000) begin n_err++;
      $display("FAIL reset_flags: got %b want 0000", {bus_valid, rd_en, busy, timeout_err}); end
    n_cmp++; if ({bus_unit, bus_reg, bus_data} !== 32'h0) begin n_err++;
      $display("FAIL reset_bus: got %h want 0", {bus_unit, bus_reg, bus_data}); end
    n_cmp++; if ({cur_time, cmd_count} !== 48'h0) begin n_err++;
      $display("FAIL reset_counters: got %h want 0", {cur_time, cmd_count}); end
    rst = 1'b0;
    tick(1);
    n_cmp++; if (cur_time !== 32'd1) begin n_err++;
      $display("FAIL reset_time_start: got %0d want 1", cur_time); end
  endtask

  // Immediate-start command, ack the cycle after valid
  task automatic test_basic;
    int b, p, s;
    bit ok;
    ack_wait = 0;
    b = nrise; p = rd_pulses; s = cyc;
    push(32'd0, 8'h03, 8'h10, 16'hBEEF);
    wait_valid(20, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_valid: got none want bus_valid"); end
    tick(4);
    n_cmp++; if (nrise - b !== 1 || rise_cyc[b] - s !== 4) begin n_err++;
      $display("FAIL basic_latency: got %0d want 4", rise_cyc[b] - s); end
    n_cmp++; if ({bus_unit, bus_reg, bus_data} !== 32'h0310BEEF) begin n_err++;
      $display("FAIL basic_fields: got %h want 0310beef", {bus_unit, bus_reg, bus_data}); end
    n_cmp++; if (rd_pulses - p !== 1) begin n_err++;
      $display("FAIL basic_rd_pulses: got %0d want 1", rd_pulses - p); end
    n_cmp++; if (cmd_count !== 16'd1 || busy !== 1'b0) begin n_err++;
      $display("FAIL basic_done: got count %0d busy %b want 1 0", cmd_count, busy); end
  endtask

  // start=150 pushed at cur_time=100: WAIT sees 150, EXEC at 151, valid at 152
  task automatic test_wait_time;
    bit ok;
    int n, bad;
    logic [31:0] t0;
    ack_wait = 3;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cur_time == 32'd100) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wait_reach100: got %0d want 100", cur_time); end
    push(32'd150, 8'h02, 8'h22, 16'h1234);
    wait_valid(100, ok);
    t0 = cur_time;
    n_cmp++; if (!ok || t0 !== 32'd152) begin n_err++;
      $display("FAIL wait_rise_time: got %0d want 152", t0); end
    n = 0; bad = 0;
    for (int i = 0; i < 20 && bus_valid; i++) begin
      if ({bus_unit, bus_reg, bus_data} !== 32'h02221234) bad++;
      n++;
      @(negedge clk);
    end
    n_cmp++; if (n !== 4 || bad !== 0) begin n_err++;
      $display("FAIL wait_hold: got %0d cycles %0d bad want 4 cycles 0 bad", n, bad); end
    n_cmp++; if (cmd_count !== 16'd2) begin n_err++;
      $display("FAIL wait_count: got %0d want 2", cmd_count); end
  endtask

  // ACK_TIMEOUT=8, no ack
  task automatic test_timeout;
    bit ok;
    int n;
    ack_wait = -1;
    push(32'd0, 8'h05, 8'h33, 16'h5555);
    wait_valid(20, ok);
    n = 0;
    for (int i = 0; i < 30 && bus_valid; i++) begin n++; @(negedge clk); end
    n_cmp++; if (!ok || n !== 8) begin n_err++;
      $display("FAIL timeout_len: got %0d want 8", n); end
    n_cmp++; if (timeout_err !== 1'b1 || cmd_count !== 16'd2) begin n_err++;
      $display("FAIL timeout_flag: got err %b count %0d want 1 2", timeout_err, cmd_count); end
    tick(3);
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++;
      $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
    err_clear = 1'b1; tick(1); err_clear = 1'b0;
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++;
      $display("FAIL timeout_clear: got %b want 0", timeout_err); end
    // err_clear held on the cycle the second timeout fires
    push(32'd0, 8'h06, 8'h34, 16'h6666);
    wait_valid(20, ok);
    n = 0;
    for (int i = 0; i < 30 && bus_valid; i++) begin
      n++;
      if (n == 8) err_clear = 1'b1;
      @(negedge clk);
    end
    err_clear = 1'b0;
    n_cmp++; if (!ok || timeout_err !== 1'b1) begin n_err++;
      $display("FAIL timeout_set_wins: got %b want 1", timeout_err); end
    err_clear = 1'b1; tick(1); err_clear = 1'b0;
  endtask

  // Control clear then start=5: clear at IDLE(0), POP 1, LATCH 2, WAIT 3..5, EXEC 6, valid at 7
  task automatic test_ctrl;
    bit ok;
    int b, f;
    ack_wait = 0;
    b = nrise; f = ff_seen;
    push(32'd0, 8'hFF, 8'h01, 16'h0000);
    push(32'd5, 8'h01, 8'h44, 16'hABCD);
    wait_count(16'd3, 40, ok);
    n_cmp++; if (!ok || cur_time !== 32'd0) begin n_err++;
      $display("FAIL ctrl_clear: got %0d want 0", cur_time); end
    wait_valid(40, ok);
    n_cmp++; if (!ok || cur_time !== 32'd7 || bus_unit !== 8'h01) begin n_err++;
      $display("FAIL ctrl_second_issue: got t=%0d unit %h want t=7 unit 01", cur_time, bus_unit); end
    wait_count(16'd4, 20, ok);
    tick(2);
    n_cmp++; if (!ok || nrise - b !== 1 || ff_seen != f) begin n_err++;
      $display("FAIL ctrl_bus_use: got %0d rises %0d ff want 1 0", nrise - b, ff_seen - f); end
  endtask

  task automatic test_back_to_back;
    int b, p;
    bit ok;
    ack_wait = 0;
    b = nrise; p = rd_pulses;
    push(32'd0, 8'h11, 8'h01, 16'h0011);
    push(32'd0, 8'h12, 8'h02, 16'h0012);
    push(32'd0, 8'h13, 8'h03, 16'h0013);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (nrise >= b + 3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tick(4);
    n_cmp++; if (!ok || {rise_u[b], rise_u[b+1], rise_u[b+2]} !== 24'h111213) begin n_err++;
      $display("FAIL b2b_order: got %h%h%h want 111213", rise_u[b], rise_u[b+1], rise_u[b+2]); end
    n_cmp++; if (rise_cyc[b+1] - rise_cyc[b] !== 5 || rise_cyc[b+2] - rise_cyc[b+1] !== 5) begin n_err++;
      $display("FAIL b2b_spacing: got %0d %0d want 5 5",
               rise_cyc[b+1] - rise_cyc[b], rise_cyc[b+2] - rise_cyc[b+1]); end
    n_cmp++; if (rd_pulses - p !== 3 || cmd_count !== 16'd7) begin n_err++;
      $display("FAIL b2b_totals: got %0d pulses count %0d want 3 7", rd_pulses - p, cmd_count); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    ack_wait = -1;
    push(32'd0, 8'h21, 8'h01, 16'h2121);
    wait_valid(20, ok);
    rst = 1'b1; tick(1);
    n_cmp++; if (!ok || {bus_valid, rd_en, busy, timeout_err} !== 4'b0000 || {cur_time, cmd_count} !== 48'h0) begin n_err++;
      $display("FAIL rst_issue: got %b %h want 0000 0", {bus_valid, rd_en, busy, timeout_err}, {cur_time, cmd_count}); end
    rst = 1'b0; tick(3);
    n_cmp++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL rst_no_reissue: got busy %b want 0", busy); end
    push(32'd0, 8'h22, 8'h02, 16'h2222);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rd_en) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    rst = 1'b1; tick(1);
    n_cmp++; if (!ok || {rd_en, busy, bus_valid} !== 3'b000) begin n_err++;
      $display("FAIL rst_pop: got %b want 000", {rd_en, busy, bus_valid}); end
    rst = 1'b0; tick(3);
    ack_wait = 0;
    push(32'd0, 8'h23, 8'h03, 16'h2323);
    wait_valid(20, ok);
    n_cmp++; if (!ok || bus_unit !== 8'h23) begin n_err++;
      $display("FAIL rst_next_cmd: got unit %h want 23", bus_unit); end
    tick(3);
    n_cmp++; if (cmd_count !== 16'd1) begin n_err++;
      $display("FAIL rst_next_count: got %0d want 1", cmd_count); end
  endtask

  initial begin
    rst = 1'b1;
    err_clear = 1'b0;
    test_reset;
    test_basic;
    test_wait_time;
    test_timeout;
    test_ctrl;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
